// File: rtl/demux8way16_bank_if.sv
// Bundle of the write-side controls and bank outputs of demux8way16_bank.
// Latency: none (wires only); bank outputs are registered inside the block.
// Backpressure: none; the producer writes one word per clock via load.
interface demux8way16_bank_if;
    // write side
    logic [15:0] in;
    logic        load;
    logic [2:0]  sel;
    logic        auto;
    // bank side
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
    logic [15:0] e;
    logic [15:0] f;
    logic [15:0] g;
    logic [15:0] h;
    logic [2:0]  ptr;
    logic [7:0]  valid;
    logic        full;
    logic        wrapped;

    // producer that fills the bank and watches its state
    modport master (
        output in, load, sel, auto,
        input  a, b, c, d, e, f, g, h, ptr, valid, full, wrapped
    );

    // the bank itself
    modport slave (
        input  in, load, sel, auto,
        output a, b, c, d, e, f, g, h, ptr, valid, full, wrapped
    );
endinterface

// File: rtl/demux8way16_bank.sv
// 8-entry x 16-bit register bank: steers one input word per clock to an explicit or auto-pointer target.
// Latency: one clock from the edge sampling load=1 to the updated register, ptr, valid and wrapped.
// Backpressure: none; every load is accepted, writes after full simply overwrite.
module demux8way16_bank (
    input  logic                  clock,
    input  logic                  reset,
    demux8way16_bank_if.slave     bus
);

    // Pointer states; the encoding doubles as the register index.
    typedef enum logic [2:0] {
        P0 = 3'd0,
        P1 = 3'd1,
        P2 = 3'd2,
        P3 = 3'd3,
        P4 = 3'd4,
        P5 = 3'd5,
        P6 = 3'd6,
        P7 = 3'd7
    } ptr_state_t;

    ptr_state_t  ptr_q;
    ptr_state_t  ptr_d;
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [7:0]  valid_q;
    logic [7:0]  valid_d;
    logic        wrapped_q;
    logic        wrapped_d;

    logic [2:0]  tgt;
    logic [7:0]  wr_onehot;
    logic        advance;

    // Resolve the write target and decode it to a one-hot write enable.
    always_comb begin
        tgt       = bus.auto ? ptr_q : bus.sel;
        advance   = bus.load & bus.auto;
        wr_onehot = 8'h00;
        if (bus.load) begin
            wr_onehot = 8'h01 << tgt;
        end
    end

    // Next bank contents: only the addressed entry takes the input word.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_onehot[i]) begin
                regs_d[i] = bus.in;
            end
        end
    end

    // Written-since-reset flags are sticky; only reset clears them.
    always_comb begin
        valid_d = valid_q | wr_onehot;
    end

    // Pointer FSM next state: step on an auto write, otherwise hold.
    always_comb begin
        ptr_d = ptr_q;
        case (ptr_q)
            P0:      ptr_d = advance ? P1 : P0;
            P1:      ptr_d = advance ? P2 : P1;
            P2:      ptr_d = advance ? P3 : P2;
            P3:      ptr_d = advance ? P4 : P3;
            P4:      ptr_d = advance ? P5 : P4;
            P5:      ptr_d = advance ? P6 : P5;
            P6:      ptr_d = advance ? P7 : P6;
            P7:      ptr_d = advance ? P0 : P7;
            default: ptr_d = P0;
        endcase
    end

    // Wrap pulse: only the auto write that leaves P7 raises it, for one cycle.
    always_comb begin
        wrapped_d = advance && (ptr_q == P7);
    end

    // Pointer FSM and its registered wrap flag; reset wins over a simultaneous load.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q     <= P0;
            wrapped_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Bank storage and valid flags; reset discards any write on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
            valid_q <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            valid_q <= valid_d;
        end
    end

    // Drive the bank outputs; full is a pure function of the valid flags.
    assign bus.a       = regs_q[0];
    assign bus.b       = regs_q[1];
    assign bus.c       = regs_q[2];
    assign bus.d       = regs_q[3];
    assign bus.e       = regs_q[4];
    assign bus.f       = regs_q[5];
    assign bus.g       = regs_q[6];
    assign bus.h       = regs_q[7];
    assign bus.ptr     = ptr_q;
    assign bus.valid   = valid_q;
    assign bus.full    = &valid_q;
    assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_demux8way16_bank.sv
module tb_demux8way16_bank;

    logic clock;
    logic reset;

    demux8way16_bank_if bus ();

    demux8way16_bank dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bank as an array, pointer as an integer mod 8.
    logic [15:0] m_regs [8];
    int          m_ptr;
    logic [7:0]  m_valid;
    logic        m_wr;

    function automatic logic [140:0] exp_vec();
        return {m_regs[0], m_regs[1], m_regs[2], m_regs[3],
                m_regs[4], m_regs[5], m_regs[6], m_regs[7],
                3'(m_ptr), m_valid, (m_valid == 8'hFF), m_wr};
    endfunction

    function automatic logic [140:0] obs_vec();
        return {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h,
                bus.ptr, bus.valid, bus.full, bus.wrapped};
    endfunction

    function automatic logic [15:0] obs_reg(input int i);
        case (i)
            0: return bus.a;
            1: return bus.b;
            2: return bus.c;
            3: return bus.d;
            4: return bus.e;
            5: return bus.f;
            6: return bus.g;
            default: return bus.h;
        endcase
    endfunction

    // One clock: drive on the falling edge, advance the model at the rising edge, settle.
    task automatic cyc(input logic rst, input logic ld, input logic [2:0] sl,
                       input logic au, input logic [15:0] din);
        int tgt;
        @(negedge clock);
        reset    = rst;
        bus.load = ld;
        bus.sel  = sl;
        bus.auto = au;
        bus.in   = din;
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_ptr = 0; m_valid = 8'h00; m_wr = 1'b0;
        end else if (ld) begin
            tgt = au ? m_ptr : int'(sl);
            m_regs[tgt]  = din;
            m_valid[tgt] = 1'b1;
            if (au) begin
                m_wr  = (m_ptr == 7);
                m_ptr = (m_ptr + 1) % 8;
            end else begin
                m_wr = 1'b0;
            end
        end else begin
            m_wr = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 16'h0000);
        n_tests++;
        if (obs_vec() !== 141'd0) begin
            n_fail++;
            $display("FAIL reset_state obs=%h exp=0", obs_vec());
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 3'($urandom), 1'($urandom), 16'($urandom));
            n_tests++;
            if (obs_vec() !== 141'd0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle obs=%h exp=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_explicit();
        logic [15:0] vals [8] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
                                  16'h5678, 16'h6789, 16'h789A, 16'h89AB};
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 3'(k), 1'b0, vals[k]);
            n_tests++;
            if (bus.ptr !== 3'd0 || bus.wrapped !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL explicit_step%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (obs_reg(k) !== vals[k]) begin
                n_fail++;
                $display("FAIL explicit_reg%0d got=%h want=%h", k, obs_reg(k), vals[k]);
            end
        end
        n_tests++;
        if (bus.valid !== 8'hFF || bus.full !== 1'b1) begin
            n_fail++;
            $display("FAIL explicit_full valid=%h full=%b want FF/1", bus.valid, bus.full);
        end
    endtask

    task automatic test_auto_fill();
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 16'h0000);
        for (int k = 0; k < 9; k++) begin
            cyc(1'b0, 1'b1, 3'($urandom), 1'b1, 16'(k + 1));
            n_tests++;
            if (bus.ptr !== 3'((k + 1) % 8) || bus.wrapped !== (k == 7)) begin
                n_fail++;
                $display("FAIL auto_ptr%0d ptr=%0d wrapped=%b want %0d/%b",
                         k, bus.ptr, bus.wrapped, (k + 1) % 8, (k == 7));
            end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL auto_state%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (bus.a !== 16'h0009 || bus.b !== 16'h0002 || bus.h !== 16'h0008) begin
            n_fail++;
            $display("FAIL auto_final a=%h b=%h h=%h want 0009/0002/0008", bus.a, bus.b, bus.h);
        end
    endtask

    task automatic test_mixed();
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 3'd5, 1'b1, 16'hAAAA);
        cyc(1'b0, 1'b1, 3'd5, 1'b1, 16'hBBBB);
        cyc(1'b0, 1'b1, 3'd6, 1'b0, 16'hCCCC);
        cyc(1'b0, 1'b1, 3'd1, 1'b1, 16'hDDDD);
        n_tests++;
        if (bus.a !== 16'hAAAA || bus.b !== 16'hBBBB || bus.c !== 16'hDDDD ||
            bus.g !== 16'hCCCC || bus.ptr !== 3'd3 || bus.valid !== 8'h47) begin
            n_fail++;
            $display("FAIL mixed a=%h b=%h c=%h g=%h ptr=%0d valid=%h", bus.a, bus.b,
                     bus.c, bus.g, bus.ptr, bus.valid);
        end
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL mixed_model obs=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_collision();
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 16'h0000);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 3'd0, 1'b1, 16'($urandom));
        n_tests++;
        if (bus.ptr !== 3'd5) begin
            n_fail++;
            $display("FAIL collision_pre ptr=%0d want 5", bus.ptr);
        end
        cyc(1'b1, 1'b1, 3'd0, 1'b1, 16'hFFFF);
        n_tests++;
        if (obs_vec() !== 141'd0) begin
            n_fail++;
            $display("FAIL collision obs=%h exp=0", obs_vec());
        end
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 16'hFFFF);
        n_tests++;
        if (obs_vec() !== 141'd0) begin
            n_fail++;
            $display("FAIL collision_after obs=%h exp=0", obs_vec());
        end
    endtask

    task automatic test_hold();
        logic [140:0] snap;
        cyc(1'b0, 1'b1, 3'd4, 1'b0, 16'h5678);
        snap = exp_vec();
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, 3'($urandom), 1'($urandom), 16'($urandom));
            n_tests++;
            if (obs_vec() !== snap || bus.e !== 16'h5678 || bus.wrapped !== 1'b0) begin
                n_fail++;
                $display("FAIL hold%0d obs=%h exp=%h", k, obs_vec(), snap);
            end
        end
    endtask

    task automatic test_random();
        logic rst;
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            cyc(rst, 1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom),
                16'($urandom));
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.sel  = 3'd0;
        bus.auto = 1'b0;
        bus.in   = 16'h0000;
        test_reset();
        test_explicit();
        test_auto_fill();
        test_mixed();
        test_reset_collision();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux8way16_bank.md
# demux8way16_bank

Sequential 8-way, 16-bit distributor: the write-side counterpart of the 8-way 16-bit multiplexer. A single 16-bit input word is steered into one of eight held output registers `a`..`h`, selected either by an explicit 3-bit select or by an internal auto-incrementing write pointer. It sits in front of the 8-way mux/RAM8-class datapath, filling register banks one word per clock.

## Interface
- No parameters. Width is fixed at 16 bits and depth at 8.
- `clock`  in  1  Rising-edge clock; the only clock.
- `reset`  in  1  Synchronous, active-high reset.
- `in`  in  16  Data word to store.
- `load`  in  1  Write strobe, sampled at the rising edge.
- `sel`  in  3  Explicit target index when `auto`=0 (0=a … 7=h).
- `auto`  in  1  1 = target is the internal pointer `ptr`, which advances after each write.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h`  out  16 each  Registered bank contents.
- `ptr`  out  3  Current auto-write pointer.
- `valid`  out  8  Bit i set once register i has been written since reset (bit 0 = `a`).
- `full`  out  1  Combinational AND of all `valid` bits.
- `wrapped`  out  1  One-cycle pulse following an auto write that moved `ptr` from 7 to 0.

## Operation
- Target index: `tgt = auto ? ptr : sel`.
- At each rising edge with `reset`=0 and `load`=1:
  - register[`tgt`] <= `in`; all other registers hold;
  - `valid[tgt]` <= 1.
  - If `auto`=1: `ptr` <= `ptr`+1 mod 8. `wrapped` <= 1 iff the old `ptr` was 7; otherwise `wrapped` <= 0.
  - If `auto`=0: `ptr` holds and `wrapped` <= 0.
- At each rising edge with `load`=0: all state holds and `wrapped` <= 0.
- Pointer FSM: eight states P0..P7. Pn -> P(n+1 mod 8) only on `load`&`auto`; otherwise it stays in Pn. There is no other transition except reset -> P0.
- Rewriting a register overwrites its contents; the `valid` bit stays 1.
- `valid` bits clear only on reset.
- `full` stays 1 after all eight registers are written; further writes are accepted normally. There is no overflow block.
- Switching `auto` between writes is legal. Explicit writes do not disturb `ptr`, so auto-fill resumes where it left off.
- `sel` is ignored when `auto`=1. `in`, `sel` and `auto` are don't-care when `load`=0.

## Timing
- Reset, synchronous: at an edge with `reset`=1:
  - `a`..`h` = 16'h0000;
  - `ptr` = 0;
  - `valid` = 8'h00;
  - `wrapped` = 0;
  - `full` = 0.
- `reset` overrides a simultaneous `load`: that write is discarded.
- A reset asserted mid-fill, e.g. with `ptr`=5, returns `ptr` to 0 on that edge.
- Write latency is one clock. New data appears on the output register at the edge that samples `load`=1 and is stable for the full following cycle.
- Writes are back-to-back capable: one word per clock, with no bubbles and no handshake beyond `load`.
- `ptr`, `valid` and `wrapped` update on the same edge as the data write.
- `full` follows `valid` combinationally.

## Test plan
- Reset, then hold `load`=0 for 3 clocks -> all outputs 0, `ptr`=0, `valid`=00, `full`=0, `wrapped`=0.
- Explicit writes with `auto`=0, `load`=1:
  - drive `sel`=0..7 on consecutive clocks with `in` = 1234, 2345, 3456, 4567, 5678, 6789, 789A, 89AB (hex);
  - required: `a`..`h` hold those values respectively, `valid`=FF, `full`=1, `ptr`=0 throughout, `wrapped` never asserted.
- Auto fill with `auto`=1:
  - write 8 words 0001..0008 back-to-back, then a 9th word 0009;
  - required: `a`..`h` = 0009, 0002..0008;
  - `ptr` sequence 1,2,…,7,0,1;
  - `wrapped`=1 for exactly the cycle after the 8th write.
- Mixed mode:
  - auto-write 0xAAAA and 0xBBBB, so `ptr`=2;
  - explicit write `sel`=6, `in`=0xCCCC;
  - auto-write 0xDDDD;
  - required: `a`=AAAA, `b`=BBBB, `c`=DDDD, `g`=CCCC, `ptr`=3, `valid`=0x47.
- Reset collision: with `ptr`=5, assert `reset` and `load` together, with `in`=0xFFFF, `auto`=1 -> next cycle all registers 0, `ptr`=0, `valid`=00. The 0xFFFF write is never visible.
- Hold: after writing `e`=0x5678, leave `load`=0 for 10 clocks while toggling `in`/`sel`/`auto` randomly -> all outputs, `ptr` and `valid` unchanged, `wrapped`=0.
